// File: rtl/apb_bridge_fsm_if.sv
// Bus interface of the AHB-to-APB bridge sequencer.
// Groups the AHB-side (valid, Hwrite, tempselx, Haddr, Hwdata, Hreadyout, Hrdata)
// and APB-side (Pselx, Penable, Pwrite, Paddr, Pwdata, Prdata, Pready) signals,
// plus the timeout_err status pulse.
//   slave  : view used by the bridge (consumes AHB requests and APB responses)
//   master : view used by the environment driving the bridge
interface apb_bridge_fsm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              Hwrite;
  logic [2:0]        tempselx;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Prdata;
  logic              Pready;
  logic              Hreadyout;
  logic [DATA_W-1:0] Hrdata;
  logic [2:0]        Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              timeout_err;

  modport slave (
    input  valid, Hwrite, tempselx, Haddr, Hwdata, Prdata, Pready,
    output Hreadyout, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata, timeout_err
  );

  modport master (
    output valid, Hwrite, tempselx, Haddr, Hwdata, Prdata, Pready,
    input  Hreadyout, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata, timeout_err
  );
endinterface

// File: rtl/apb_bridge_fsm.sv
// Sequencing controller of the AHB-to-APB bridge.
// Accepts one qualified AHB transfer at a time, stalls AHB through Hreadyout,
// runs one APB SETUP+ACCESS transaction per transfer, returns registered read
// data, and aborts an ACCESS phase that waits longer than TIMEOUT cycles.
// Ports:
//   Hclk     : bridge clock, rising edge
//   Hresetn  : asynchronous active-low reset
//   bus      : apb_bridge_fsm_if.slave (AHB request/response + APB bus + timeout_err)
// All outputs come from registers or are decoded from the state register.
module apb_bridge_fsm #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             Hclk,
  input  logic             Hresetn,
  apb_bridge_fsm_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WWAIT,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t            r_state;
  logic [2:0]        r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_pselx;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_hrdata;
  logic              r_terr;

  // APB address/control registers are loaded on the edge that enters SETUP,
  // so they already present sel/addr/dir throughout the SETUP cycle.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_pselx   <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_hrdata  <= '0;
      r_terr    <= 1'b0;
    end else begin
      r_terr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.valid) begin
            r_addr <= bus.Haddr;
            r_sel  <= bus.tempselx;
            if (bus.Hwrite) begin
              r_state <= S_WWAIT;
            end else begin
              r_pselx  <= bus.tempselx;
              r_paddr  <= bus.Haddr;
              r_pwrite <= 1'b0;
              r_state  <= S_SETUP;
            end
          end
        end
        S_WWAIT: begin
          r_pwdata <= bus.Hwdata;
          r_pselx  <= r_sel;
          r_paddr  <= r_addr;
          r_pwrite <= 1'b1;
          r_state  <= S_SETUP;
        end
        S_SETUP: begin
          r_cnt     <= '0;
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (bus.Pready) begin
            if (!r_pwrite) r_hrdata <= bus.Prdata;
            r_pselx   <= '0;
            r_penable <= 1'b0;
            r_state   <= S_IDLE;
          end else if (TO_EN && (r_cnt == CNT_LAST)) begin
            r_hrdata  <= '0;
            r_terr    <= 1'b1;
            r_pselx   <= '0;
            r_penable <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Hreadyout   = (r_state == S_IDLE);
  assign bus.Hrdata      = r_hrdata;
  assign bus.Pselx       = r_pselx;
  assign bus.Penable     = r_penable;
  assign bus.Pwrite      = r_pwrite;
  assign bus.Paddr       = r_paddr;
  assign bus.Pwdata      = r_pwdata;
  assign bus.timeout_err = r_terr;

endmodule

// File: tb/tb_apb_bridge_fsm.sv
// Self-checking bench for apb_bridge_fsm: directed vector table, an
// asynchronous-reset sequence, and randomized transfers against a
// transaction-level model (busy cycles, read data, timeout pulse).
module tb_apb_bridge_fsm;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic Hclk = 1'b0;
  logic Hresetn;
  always #5 Hclk = ~Hclk;

  apb_bridge_fsm_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  apb_bridge_fsm #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] m_hrdata;

  typedef struct {
    bit          w;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int unsigned waits;
    int unsigned busy;
    logic [31:0] hrdata;
    bit          terr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left shortly after a rising edge in an IDLE cycle, so
  // consecutive calls issue transfers back to back.
  task automatic xfer(input bit w, input logic [2:0] sel, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] prdata,
                      input int unsigned waits, input int unsigned exp_busy,
                      input logic [DW-1:0] exp_hrdata, input bit exp_terr);
    int unsigned busy;
    int unsigned i;
    bit done;
    busy = 0;
    bus_if.valid    = 1'b1;
    bus_if.Hwrite   = w;
    bus_if.tempselx = sel;
    bus_if.Haddr    = addr;
    bus_if.Prdata   = prdata;
    bus_if.Pready   = 1'($urandom);
    bus_if.Hwdata   = $urandom;
    @(negedge Hclk);
    check("accept_hready", 64'(bus_if.Hreadyout), 64'd1);
    @(posedge Hclk); #1;
    bus_if.valid    = 1'($urandom);
    bus_if.Hwrite   = 1'($urandom);
    bus_if.tempselx = 3'($urandom);
    bus_if.Haddr    = $urandom;
    if (w) begin
      bus_if.Hwdata = wdata;
      @(negedge Hclk);
      if (!bus_if.Hreadyout) busy++;
      check("dphase_pselx", 64'(bus_if.Pselx), 64'd0);
      check("dphase_terr", 64'(bus_if.timeout_err), 64'd0);
      @(posedge Hclk); #1;
      bus_if.Hwdata = $urandom;
      bus_if.valid  = 1'($urandom);
    end
    @(negedge Hclk);
    if (!bus_if.Hreadyout) busy++;
    check("setup_pselx", 64'(bus_if.Pselx), 64'(sel));
    check("setup_penable", 64'(bus_if.Penable), 64'd0);
    check("setup_paddr", 64'(bus_if.Paddr), 64'(addr));
    check("setup_pwrite", 64'(bus_if.Pwrite), 64'(w));
    if (!w) check("setup_terr", 64'(bus_if.timeout_err), 64'd0);
    if (w) check("setup_pwdata", 64'(bus_if.Pwdata), 64'(wdata));
    @(posedge Hclk); #1;
    done = 1'b0;
    i = 0;
    while (!done) begin
      bus_if.Pready = (i == waits);
      bus_if.valid  = 1'($urandom);
      @(negedge Hclk);
      if (!bus_if.Hreadyout) busy++;
      check("access_penable", 64'(bus_if.Penable), 64'd1);
      check("access_pselx", 64'(bus_if.Pselx), 64'(sel));
      check("access_paddr", 64'(bus_if.Paddr), 64'(addr));
      if (w) check("access_pwdata", 64'(bus_if.Pwdata), 64'(wdata));
      if ((i == waits) || (i == TO - 1)) done = 1'b1;
      i++;
      @(posedge Hclk); #1;
    end
    bus_if.valid  = 1'b0;
    bus_if.Pready = 1'($urandom);
    check("busy_cycles", 64'(busy), 64'(exp_busy));
    check("done_hready", 64'(bus_if.Hreadyout), 64'd1);
    check("done_pselx", 64'(bus_if.Pselx), 64'd0);
    check("done_penable", 64'(bus_if.Penable), 64'd0);
    check("done_paddr_hold", 64'(bus_if.Paddr), 64'(addr));
    check("done_hrdata", 64'(bus_if.Hrdata), 64'(exp_hrdata));
    check("done_terr", 64'(bus_if.timeout_err), 64'(exp_terr));
  endtask

  initial begin
    bit          w;
    bit          term;
    logic [2:0]  sel;
    int unsigned waits;
    int unsigned exp_busy;
    logic [DW-1:0] prdata;
    logic [DW-1:0] exp_hr;

    vecs[0] = '{1'b0, 3'b001, 32'h8000_0010, 32'h0,         32'h1234_5678, 0,  2,  32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 3'b010, 32'h8400_0004, 32'hA5A5_A5A5, 32'hDEAD_0001, 0,  3,  32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 3'b001, 32'h8000_0020, 32'h0,         32'hCAFE_F00D, 3,  5,  32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b0, 3'b001, 32'h8000_0000, 32'h0,         32'h0BAD_BEEF, 0,  2,  32'h0BAD_BEEF, 1'b0};
    vecs[4] = '{1'b1, 3'b100, 32'h8800_0008, 32'h1122_3344, 32'hDEAD_0002, 1,  4,  32'h0BAD_BEEF, 1'b0};
    vecs[5] = '{1'b0, 3'b001, 32'h8000_0030, 32'h0,         32'h5555_AAAA, 30, 17, 32'h0,         1'b1};
    vecs[6] = '{1'b1, 3'b010, 32'h8400_0040, 32'h0F0F_0F0F, 32'hDEAD_0003, 15, 18, 32'h0,         1'b0};
    vecs[7] = '{1'b0, 3'b001, 32'h8000_0044, 32'h0,         32'h7777_1234, 14, 16, 32'h7777_1234, 1'b0};

    Hresetn         = 1'b0;
    bus_if.valid    = 1'b0;
    bus_if.Hwrite   = 1'b0;
    bus_if.tempselx = '0;
    bus_if.Haddr    = '0;
    bus_if.Hwdata   = '0;
    bus_if.Prdata   = '0;
    bus_if.Pready   = 1'b0;
    #12;
    check("rst_hready", 64'(bus_if.Hreadyout), 64'd1);
    check("rst_pselx", 64'(bus_if.Pselx), 64'd0);
    check("rst_penable", 64'(bus_if.Penable), 64'd0);
    check("rst_pwrite", 64'(bus_if.Pwrite), 64'd0);
    check("rst_paddr", 64'(bus_if.Paddr), 64'd0);
    check("rst_pwdata", 64'(bus_if.Pwdata), 64'd0);
    check("rst_hrdata", 64'(bus_if.Hrdata), 64'd0);
    check("rst_terr", 64'(bus_if.timeout_err), 64'd0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    @(posedge Hclk); #1;

    for (int k = 0; k < 8; k++) begin
      xfer(vecs[k].w, vecs[k].sel, vecs[k].addr, vecs[k].wdata, vecs[k].prdata,
           vecs[k].waits, vecs[k].busy, vecs[k].hrdata, vecs[k].terr);
    end
    m_hrdata = vecs[7].hrdata;

    // Reset asserted in the middle of an ACCESS phase.
    bus_if.valid    = 1'b1;
    bus_if.Hwrite   = 1'b0;
    bus_if.tempselx = 3'b001;
    bus_if.Haddr    = 32'h8000_0050;
    bus_if.Pready   = 1'b0;
    @(posedge Hclk); #1;
    bus_if.valid = 1'b0;
    @(posedge Hclk); #1;
    check("pre_rst_penable", 64'(bus_if.Penable), 64'd1);
    #2;
    Hresetn = 1'b0;
    #1;
    check("arst_pselx", 64'(bus_if.Pselx), 64'd0);
    check("arst_penable", 64'(bus_if.Penable), 64'd0);
    check("arst_hready", 64'(bus_if.Hreadyout), 64'd1);
    check("arst_hrdata", 64'(bus_if.Hrdata), 64'd0);
    check("arst_paddr", 64'(bus_if.Paddr), 64'd0);
    m_hrdata = '0;
    @(negedge Hclk);
    Hresetn = 1'b1;
    @(posedge Hclk); #1;
    xfer(1'b0, 3'b010, 32'h8400_0060, 32'h0, 32'h9876_5432, 1, 3, 32'h9876_5432, 1'b0);
    m_hrdata = 32'h9876_5432;

    // Randomized transfers against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      w      = 1'($urandom_range(0, 1));
      sel    = 3'(1 << $urandom_range(0, 2));
      prdata = $urandom;
      waits  = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4);
      term   = (waits >= TO);
      exp_busy = (w ? 1 : 0) + 1 + (term ? TO : waits + 1);
      exp_hr = term ? '0 : (w ? m_hrdata : prdata);
      xfer(w, sel, $urandom, $urandom, prdata, waits, exp_busy, exp_hr, term);
      m_hrdata = exp_hr;
    end

    @(posedge Hclk); #1;
    check("final_terr", 64'(bus_if.timeout_err), 64'd0);
    check("final_hready", 64'(bus_if.Hreadyout), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
